// File: rtl/pos_cell_reader_pkg.sv
// Shared cell definitions for the particle-position cell reader and its FIFO.
package pos_cell_reader_pkg;

    localparam int POS_WIDTH         = 32;
    localparam int CELL_DATA_WIDTH   = 3 * POS_WIDTH;
    localparam int CELL_ADDR_WIDTH   = 8;
    localparam int CELL_PARTICLE_NUM = 220;

    localparam int FIFO_DEPTH = 4;
    localparam int RD_LATENCY = 2;

    typedef struct packed {
        logic [POS_WIDTH-1:0] posz;
        logic [POS_WIDTH-1:0] posy;
        logic [POS_WIDTH-1:0] posx;
    } pos_t;

endpackage

// File: rtl/pos_fifo_sync.sv
// Single-clock FIFO with occupancy count; storage is cleared on reset so the
// read port shows zero until the first word is written.
module pos_fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        ptr_inc = (p == LAST_PTR) ? {PW{1'b0}} : p + {{(PW-1){1'b0}}, 1'b1};
    endfunction

    // Pointer, occupancy and storage next-state
    always_comb begin
        do_pop   = pop && (count_q != {CW{1'b0}});
        do_push  = push && ((count_q != FULL_CNT) || do_pop);
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign empty = (count_q == {CW{1'b0}});
    assign count = count_q;

endmodule

// File: rtl/pos_cell_reader.sv
// Reads a cell's particle count from word 0, then streams words 1..N through a
// small FIFO with credit-based read issue so no returning word is ever dropped.
module pos_cell_reader
    import pos_cell_reader_pkg::*;
#(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  out_last,
    output logic [ADDR_WIDTH-1:0] particle_count,
    output logic                  busy,
    output logic                  done,
    output logic                  count_err
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CNT_RD   = 3'd1;
    localparam logic [2:0] S_CNT_WAIT = 3'd2;
    localparam logic [2:0] S_STREAM   = 3'd3;
    localparam logic [2:0] S_DRAIN    = 3'd4;

    localparam int FW = DATA_WIDTH + ADDR_WIDTH + 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = CW + 1;
    localparam logic [ADDR_WIDTH-1:0] MAX_N  = ADDR_WIDTH'(PARTICLE_NUM - 1);
    localparam logic [ADDR_WIDTH-1:0] ZERO_A = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ONE_A  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]            state_q, state_d;
    logic [RD_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH-1:0] wr_idx_q, wr_idx_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic                  count_err_q, count_err_d;
    logic                  done_q, done_d;

    logic [ADDR_WIDTH-1:0] raw_n, clamped_n;
    logic                  count_ok, issue, rd_now, push, xfer, fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [SW-1:0]         pending;
    logic [FW-1:0]         fifo_wdata, fifo_rdata;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state; a start coinciding with the done pulse is dropped
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start && !done_q) state_d = S_CNT_RD;
                else                  state_d = S_IDLE;
            end
            S_CNT_RD: state_d = S_CNT_WAIT;
            S_CNT_WAIT: begin
                if (count_ok) state_d = (clamped_n == ZERO_A) ? S_IDLE : S_STREAM;
                else          state_d = S_CNT_WAIT;
            end
            S_STREAM: begin
                if (issue && (rd_addr_q == count_q)) state_d = S_DRAIN;
                else                                 state_d = S_STREAM;
            end
            S_DRAIN: begin
                if (xfer && out_last) state_d = S_IDLE;
                else                  state_d = S_DRAIN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: a read issues only while FIFO plus in-flight words leave room
    always_comb begin
        pending = {1'b0, fifo_count};
        for (int i = 0; i < RD_LATENCY; i++) begin
            pending = pending + {{(SW-1){1'b0}}, rd_pipe_q[i]};
        end
        issue       = 1'b0;
        rd_now      = 1'b0;
        push        = 1'b0;
        mem_address = mem_address_q;
        case (state_q)
            S_CNT_RD: begin
                rd_now      = 1'b1;
                mem_address = ZERO_A;
            end
            S_STREAM: begin
                issue  = (pending < SW'(FIFO_DEPTH));
                rd_now = issue;
                push   = rd_pipe_q[RD_LATENCY-1];
                if (issue) mem_address = rd_addr_q;
                else       mem_address = mem_address_q;
            end
            S_DRAIN:  push = rd_pipe_q[RD_LATENCY-1];
            default:  push = 1'b0;
        endcase
    end

    // Datapath next-state: count capture, address/index counters, done
    always_comb begin
        raw_n         = mem_q[ADDR_WIDTH-1:0];
        count_ok      = (state_q == S_CNT_WAIT) && rd_pipe_q[RD_LATENCY-1];
        xfer          = out_valid && out_ready;
        rd_pipe_d     = {rd_pipe_q[RD_LATENCY-2:0], rd_now};
        mem_address_d = mem_address;
        count_d       = count_q;
        count_err_d   = count_err_q;
        rd_addr_d     = rd_addr_q;
        wr_idx_d      = wr_idx_q;
        if (raw_n > MAX_N) clamped_n = MAX_N;
        else               clamped_n = raw_n;
        if (count_ok) begin
            count_d     = clamped_n;
            count_err_d = count_err_q || (raw_n > MAX_N);
            rd_addr_d   = ONE_A;
            wr_idx_d    = ONE_A;
        end else begin
            if (issue) rd_addr_d = rd_addr_q + ONE_A;
            else       rd_addr_d = rd_addr_q;
            if (push)  wr_idx_d = wr_idx_q + ONE_A;
            else       wr_idx_d = wr_idx_q;
        end
        done_d = (count_ok && (clamped_n == ZERO_A)) ||
                 ((state_q == S_DRAIN) && xfer && out_last);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pipe_q     <= {RD_LATENCY{1'b0}};
            rd_addr_q     <= ZERO_A;
            wr_idx_q      <= ZERO_A;
            count_q       <= ZERO_A;
            mem_address_q <= ZERO_A;
            count_err_q   <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            rd_pipe_q     <= rd_pipe_d;
            rd_addr_q     <= rd_addr_d;
            wr_idx_q      <= wr_idx_d;
            count_q       <= count_d;
            mem_address_q <= mem_address_d;
            count_err_q   <= count_err_d;
            done_q        <= done_d;
        end
    end

    assign fifo_wdata = {(wr_idx_q == count_q), wr_idx_q, mem_q};

    pos_fifo_sync #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (xfer),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_valid                      = !fifo_empty;
    assign {out_last, out_index, out_data} = fifo_rdata;
    assign mem_rden                       = rd_now;
    assign mem_wren                       = 1'b0;
    assign busy                           = (state_q != S_IDLE);
    assign done                           = done_q;
    assign particle_count                 = count_q;
    assign count_err                      = count_err_q;

endmodule

// File: tb/tb_pos_cell_reader.sv
// Directed bench for pos_cell_reader with a 2-cycle-latency cell memory model.
module tb_pos_cell_reader;

    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;

    logic          clk = 1'b0;
    logic          rst, start, out_ready;
    logic          mem_rden, mem_wren, out_valid, out_last, busy, done, count_err;
    logic [AW-1:0] mem_address, out_index, particle_count;
    logic [DW-1:0] mem_q, out_data, mem_s1;
    logic [DW-1:0] mem [0:255];

    int n_checks = 0, n_errors = 0, cycle = 0;
    int xfer_cnt, done_cnt, rd0_cnt, valid_cnt, rd_seq, outstanding, max_out;
    int rd0_cycle, first_rd, first_valid, last_xfer, done_cycle, exp_n;
    bit sticky_err, prev_stall, h_last;
    logic [AW-1:0] h_idx;
    logic [DW-1:0] h_data;

    pos_cell_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_address(mem_address), .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_q(mem_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .particle_count(particle_count),
        .busy(busy), .done(done), .count_err(count_err)
    );

    always #5 clk = ~clk;

    // Cell memory: data for a read in cycle t is on mem_q in cycle t+2
    always @(posedge clk) begin
        if (mem_rden) mem_s1 <= mem[mem_address];
        else          mem_s1 <= {3{32'hDEAD_BEEF}};
        mem_q <= mem_s1;
    end

    function automatic logic [DW-1:0] word_of(input int i);
        word_of = {32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i * 7), 32'hC000_0000 + 32'(i * 13)};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cycle);
        end
    endtask

    task automatic monitor();
        int exp_idx;
        if (rst) begin
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            if (prev_stall)
                chk("hold", {out_valid, out_last, out_index, out_data}, {1'b1, h_last, h_idx, h_data});
            if (mem_rden) begin
                if (mem_address == 8'd0) begin
                    rd0_cnt++;
                    rd0_cycle = cycle;
                    rd_seq    = 0;
                end else begin
                    rd_seq++;
                    chk("rd_addr", mem_address, rd_seq);
                    if (first_rd < 0) first_rd = cycle;
                    outstanding++;
                    if (outstanding > max_out) max_out = outstanding;
                end
            end
            if (out_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = cycle;
            end
            if (out_valid && out_ready) begin
                exp_idx = xfer_cnt + 1;
                chk("idx", out_index, exp_idx);
                chk("data", out_data, word_of(exp_idx));
                chk("last", out_last, exp_idx == exp_n);
                xfer_cnt++;
                last_xfer = cycle;
                outstanding--;
            end
            if (done) begin
                done_cnt++;
                done_cycle = cycle;
                chk("busy_at_done", busy, 1'b0);
            end
            prev_stall = out_valid && !out_ready;
            h_last = out_last;
            h_idx  = out_index;
            h_data = out_data;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cycle++;
        #1;
    endtask

    task automatic begin_test(input int w0);
        mem[0]      = DW'(w0);
        exp_n       = (w0 > PN - 1) ? PN - 1 : w0;
        sticky_err  = sticky_err || (w0 > PN - 1);
        xfer_cnt    = 0;
        done_cnt    = 0;
        rd0_cnt     = 0;
        valid_cnt   = 0;
        first_rd    = -1;
        first_valid = -1;
    endtask

    task automatic run_cell(input int w0, input bit rand_ready, input int busy_start_at, input int budget);
        begin_test(w0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < budget && done_cnt == 0; c++) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            start = (c == busy_start_at);
            tick();
        end
        start     = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("xfers", xfer_cnt, exp_n);
        chk("dones", done_cnt, 1);
        chk("count_reads", rd0_cnt, 1);
        chk("particle_count", particle_count, exp_n);
        chk("count_err", count_err, sticky_err);
        chk("busy_end", busy, 1'b0);
        if (exp_n > 0) begin
            chk("first_rd_lat", first_rd - rd0_cycle, 3);
            chk("first_valid_lat", first_valid - first_rd, 3);
            chk("done_lat", done_cycle - last_xfer, 1);
            if (!rand_ready) chk("throughput", last_xfer - first_valid, exp_n - 1);
        end
    endtask

    initial begin
        for (int i = 1; i < 256; i++) mem[i] = word_of(i);
        mem[0] = '0; mem_s1 = '0; mem_q = '0;
        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        sticky_err = 1'b0; prev_stall = 1'b0; outstanding = 0; max_out = 0;
        rd0_cycle = 0; last_xfer = 0; done_cycle = 0; rd_seq = 0;
        repeat (3) tick();
        chk("reset_flags", {out_valid, mem_rden, mem_wren, done, busy, out_last, count_err}, 7'b0);
        chk("reset_vals", {mem_address, particle_count, out_index, out_data}, 120'b0);
        rst = 1'b0;
        tick();

        run_cell(5, 1'b0, -1, 200);

        // Empty cell, with a second start landing on the done pulse
        begin_test(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk("n0_valids", valid_cnt, 0);
        chk("n0_dones", done_cnt, 1);
        chk("n0_done_lat", done_cycle - rd0_cycle, 3);
        chk("n0_count_reads", rd0_cnt, 1);
        chk("n0_busy", busy, 1'b0);
        chk("n0_count", particle_count, 8'd0);

        run_cell(8, 1'b1, 4, 500);
        run_cell(250, 1'b0, -1, 2000);

        // Reset in the middle of streaming, then a fresh short cell
        begin_test(10);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 200 && xfer_cnt < 3; c++) tick();
        chk("pre_rst_xfers", xfer_cnt, 3);
        chk("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        sticky_err = 1'b0;
        chk("rst_flags", {out_valid, mem_rden, mem_wren, done, busy, out_last, count_err}, 7'b0);
        chk("rst_vals", {mem_address, particle_count, out_index, out_data}, 120'b0);
        rst = 1'b0;
        tick();
        run_cell(2, 1'b0, -1, 200);

        chk("max_outstanding_ok", max_out <= 4, 1'b1);
        chk("mem_wren", mem_wren, 1'b0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pos_cell_reader.md
POS_CELL_READER -- requirements
Module: pos_cell_reader

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_WIDTH, 96, packed {posz, posy, posx} word width
- ADDR_WIDTH, 8, cell memory address width
- PARTICLE_NUM, 220, memory depth in words, including word 0
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock
- rst, in, 1, synchronous active-high reset
- start, in, 1, pulse: begin one cell read-out (ignored unless IDLE)
- mem_address, out, ADDR_WIDTH, to cell memory address
- mem_rden, out, 1, cell memory read enable
- mem_wren, out, 1, tied 0
- mem_q, in, DATA_WIDTH, cell memory read data, valid 2 cycles after the rden cycle
- out_valid, out, 1, particle word available
- out_ready, in, 1, consumer accepts word
- out_data, out, DATA_WIDTH, particle position {posz, posy, posx}
- out_index, out, ADDR_WIDTH, memory address the word was read from (1..N)
- out_last, out, 1, marks the final particle of the cell
- particle_count, out, ADDR_WIDTH, clamped N, held until next start
- busy, out, 1, high in every state except IDLE
- done, out, 1, one-cycle pulse when the read-out completes
- count_err, out, 1, sticky flag: raw count exceeded PARTICLE_NUM-1

Function
REQ-003 States: IDLE, CNT_RD, CNT_WAIT, STREAM, DRAIN. Transitions:
- IDLE->CNT_RD on start
- CNT_RD->CNT_WAIT after one cycle; this cycle issues rden at address 0
- CNT_WAIT->STREAM when mem_q is valid, if N>0
- CNT_WAIT->IDLE when mem_q is valid, if N=0
- STREAM->DRAIN when the last read issues
- DRAIN->IDLE when the last word is accepted
REQ-004 N is mem_q[ADDR_WIDTH-1:0] taken from the count word. If N > PARTICLE_NUM-1, N is clamped to PARTICLE_NUM-1 and count_err is set.
REQ-005 In STREAM, the block issues reads at addresses 1..N, ascending, with at most one read per cycle.
REQ-006 Read data passes through an internal 4-entry FIFO. A read issues only when FIFO occupancy plus in-flight reads is less than 4. No word is ever dropped.
REQ-007 With out_ready held high, throughput is one word per cycle. The first out_valid appears 3 cycles after the first data read issues.
REQ-008 out_data, out_index and out_last stay stable while out_valid=1 and out_ready=0. A transfer occurs on a cycle where out_valid and out_ready are both high.
REQ-009 out_last=1 only on the word with out_index=N.
REQ-010 done pulses in the cycle after the final transfer. For N=0, done pulses in the cycle after the count word returns, and out_valid never rises.
REQ-011 mem_rden is 0 outside read-issue cycles. mem_address holds its last value when no read issues.
REQ-012 start while busy is ignored. A start in the same cycle as the done pulse is also ignored.

Reset
REQ-013 On rst, the following take these values on the next clock edge:
- state to IDLE; FIFO and in-flight counters cleared
- out_valid, mem_rden, mem_wren, done, busy, out_last, count_err to 0
- mem_address, particle_count, out_index, out_data to 0
REQ-014 rst mid-operation aborts the read-out without a done pulse. Read data returning after reset is discarded.

Structure
REQ-015 The FIFO depth constant (4) and the read latency constant (2) live in the shared define package alongside the existing cell definitions.
REQ-016 The FIFO is a separate sub-module, pos_fifo_sync: parameterised width and depth, with occupancy output.
REQ-017 State encoding is a localparam set internal to pos_cell_reader.

Verification
REQ-018 The bench models cell memory with 2-cycle latency, word0=5, and words 1..5 distinct. Start with out_ready=1 -> 5 transfers, indices 1..5 in order, out_last on index 5, done one cycle later.
REQ-019 word0=0, start -> no out_valid; done pulses exactly once; busy drops with done.
REQ-020 word0=8, out_ready toggled randomly -> all 8 words arrive in order and stable while stalled; at most 4 reads are ever outstanding.
REQ-021 word0=250 (PARTICLE_NUM=220) -> particle_count=219, count_err=1, exactly 219 transfers.
REQ-022 Assert rst during STREAM after 3 transfers -> next cycle all outputs are 0. A fresh start with word0=2 yields exactly 2 transfers.
REQ-023 Pulse start while busy -> no effect on the sequence; exactly one done.
